// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - BCD time-of-day keeper with req/ack time-set handshake
//
// Counts seconds/minutes/hours in packed BCD from rising edges of one_hz and
// accepts a software time-set over a four-phase set_req/set_ack handshake.
// Each committed set pulses trig so the divider re-phases.
//
// Ports:
//   clk        system clock (divider domain)
//   rst        asynchronous active-low reset
//   one_hz     divider output level; each rising edge is one second
//   set_req    four-phase time-set request
//   set_hh/mm/ss  BCD time to load, sampled when the request is accepted
//   set_ack    handshake acknowledge
//   set_err    qualified by set_ack; 1 = requested time rejected
//   trig       single-cycle divider re-phase pulse
//   hh/mm/ss   current BCD time
//   sec_pulse  single-cycle pulse on each time advance
//   day_pulse  single-cycle pulse on wrap to 00:00:00
//   busy       handshake FSM not idle
module rtc_timekeeper #(
    parameter int HOURS_PER_DAY = 24,
    parameter int PULSE_IN_SET  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz,
    input  logic       set_req,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_ack,
    output logic       set_err,
    output logic       trig,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       busy
);

    // BCD encodings of the hour modulus and of the last valid hour. Because
    // BCD ordering matches numeric ordering for valid digits, a plain compare
    // against HH_MAX checks the hour range.
    localparam logic [7:0] HH_MAX  = {4'(HOURS_PER_DAY / 10), 4'(HOURS_PER_DAY % 10)};
    localparam logic [7:0] HH_LAST = {4'((HOURS_PER_DAY - 1) / 10), 4'((HOURS_PER_DAY - 1) % 10)};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       one_hz_q;
    logic [7:0] sh_hh_q, sh_mm_q, sh_ss_q;
    logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic       sec_q, sec_d, day_q, day_d, trig_q, trig_d;
    logic       ack_q, ack_d, err_q, err_d, busy_q;
    logic       capture, load, adv, shadow_ok;

    // Two-digit BCD increment that wraps to 00 after 'last'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign adv = one_hz & ~one_hz_q;

    assign shadow_ok = (sh_ss_q[3:0] <= 4'd9) && (sh_ss_q[7:4] <= 4'd9) &&
                       (sh_mm_q[3:0] <= 4'd9) && (sh_mm_q[7:4] <= 4'd9) &&
                       (sh_hh_q[3:0] <= 4'd9) && (sh_hh_q[7:4] <= 4'd9) &&
                       (sh_ss_q < 8'h60) && (sh_mm_q < 8'h60) && (sh_hh_q < HH_MAX);

    // Handshake FSM: next state and control strobes.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        err_d   = err_q;
        capture = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_req) begin
                    capture = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (shadow_ok) begin
                    state_d = COMMIT;
                end else begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            COMMIT: begin
                load    = 1'b1;
                ack_d   = 1'b1;
                err_d   = 1'b0;
                state_d = HOLD;
            end
            HOLD: begin
                if (!set_req) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Time datapath. A load in COMMIT takes priority and swallows any
    // coincident one_hz edge.
    always_comb begin
        hh_d   = hh_q;
        mm_d   = mm_q;
        ss_d   = ss_q;
        sec_d  = 1'b0;
        day_d  = 1'b0;
        trig_d = load && (PULSE_IN_SET != 0);
        if (load) begin
            hh_d = sh_hh_q;
            mm_d = sh_mm_q;
            ss_d = sh_ss_q;
        end else if (adv) begin
            sec_d = 1'b1;
            ss_d  = bcd_inc(ss_q, 8'h59);
            if (ss_q == 8'h59) begin
                mm_d = bcd_inc(mm_q, 8'h59);
                if (mm_q == 8'h59) begin
                    hh_d  = bcd_inc(hh_q, HH_LAST);
                    day_d = (hh_q == HH_LAST);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            one_hz_q <= 1'b1;
            sh_hh_q  <= 8'h00;
            sh_mm_q  <= 8'h00;
            sh_ss_q  <= 8'h00;
            hh_q     <= 8'h00;
            mm_q     <= 8'h00;
            ss_q     <= 8'h00;
            sec_q    <= 1'b0;
            day_q    <= 1'b0;
            trig_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            one_hz_q <= one_hz;
            if (capture) begin
                sh_hh_q <= set_hh;
                sh_mm_q <= set_mm;
                sh_ss_q <= set_ss;
            end
            hh_q     <= hh_d;
            mm_q     <= mm_d;
            ss_q     <= ss_d;
            sec_q    <= sec_d;
            day_q    <= day_d;
            trig_q   <= trig_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign set_ack   = ack_q;
    assign set_err   = err_q;
    assign trig      = trig_q;
    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign sec_pulse = sec_q;
    assign day_pulse = day_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb/tb_rtc_timekeeper.sv - directed self-checking bench for rtc_timekeeper (24h and 12h instances)
module tb_rtc_timekeeper;

    logic       clk;
    logic       rst;
    logic       one_hz;
    logic       set_req;
    logic [7:0] set_hh, set_mm, set_ss;

    logic       ack_a, err_a, trig_a, sec_a, day_a, busy_a;
    logic [7:0] hh_a, mm_a, ss_a;
    logic       ack_b, err_b, trig_b, sec_b, day_b, busy_b;
    logic [7:0] hh_b, mm_b, ss_b;

    int total = 0;
    int bad   = 0;

    rtc_timekeeper #(.HOURS_PER_DAY(24), .PULSE_IN_SET(1)) dut_a (
        .clk(clk), .rst(rst), .one_hz(one_hz), .set_req(set_req),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_ack(ack_a), .set_err(err_a), .trig(trig_a),
        .hh(hh_a), .mm(mm_a), .ss(ss_a),
        .sec_pulse(sec_a), .day_pulse(day_a), .busy(busy_a)
    );

    rtc_timekeeper #(.HOURS_PER_DAY(12), .PULSE_IN_SET(1)) dut_b (
        .clk(clk), .rst(rst), .one_hz(one_hz), .set_req(set_req),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_ack(ack_b), .set_err(err_b), .trig(trig_b),
        .hh(hh_b), .mm(mm_b), .ss(ss_b),
        .sec_pulse(sec_b), .day_pulse(day_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_hh = h; set_mm = m; set_ss = s; set_req = 1'b1;
        tick(); tick(); tick();
        set_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; one_hz = 1'b1; set_req = 1'b0;
        set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
        #2 rst = 1'b0;
        tick(); tick();
        total++;
        if ({hh_a, mm_a, ss_a, hh_b, mm_b, ss_b} !== 48'h0) begin
            bad++; $display("FAIL reset_time got=%h exp=%h", {hh_a, mm_a, ss_a, hh_b, mm_b, ss_b}, 48'h0);
        end
        total++;
        if ({ack_a, err_a, trig_a, sec_a, day_a, busy_a, ack_b, err_b, trig_b, sec_b, day_b, busy_b} !== 12'h0) begin
            bad++; $display("FAIL reset_flags got=%b exp=%b",
                {ack_a, err_a, trig_a, sec_a, day_a, busy_a, ack_b, err_b, trig_b, sec_b, day_b, busy_b}, 12'h0);
        end
        rst = 1'b1;
        tick(); tick(); tick();
        total++;
        if ({hh_a, mm_a, ss_a, sec_a} !== 25'h0) begin
            bad++; $display("FAIL held_high_no_adv got=%h exp=%h", {hh_a, mm_a, ss_a, sec_a}, 25'h0);
        end
        one_hz = 1'b0; tick();
        one_hz = 1'b1; tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h000001 || sec_a !== 1'b1) begin
            bad++; $display("FAIL first_edge got=%h/%b exp=000001/1", {hh_a, mm_a, ss_a}, sec_a);
        end
        one_hz = 1'b0; tick();
        total++;
        if (sec_a !== 1'b0 || ss_a !== 8'h01) begin
            bad++; $display("FAIL sec_single got=%b/%h exp=0/01", sec_a, ss_a);
        end
    endtask

    task automatic test_set();
        set_hh = 8'h12; set_mm = 8'h34; set_ss = 8'h56; set_req = 1'b1;
        tick();
        // inputs are changed after capture; they must be ignored
        set_hh = 8'h07; set_mm = 8'h07; set_ss = 8'h07;
        total++;
        if (busy_a !== 1'b1 || trig_a !== 1'b0 || ack_a !== 1'b0) begin
            bad++; $display("FAIL set_check_phase got=busy%b trig%b ack%b exp=busy1 trig0 ack0", busy_a, trig_a, ack_a);
        end
        tick();
        total++;
        if (trig_a !== 1'b0 || ack_a !== 1'b0) begin
            bad++; $display("FAIL set_early got=trig%b ack%b exp=trig0 ack0", trig_a, ack_a);
        end
        tick();
        total++;
        if (trig_a !== 1'b1 || {hh_a, mm_a, ss_a} !== 24'h123456 || ack_a !== 1'b1 || err_a !== 1'b0) begin
            bad++; $display("FAIL set_commit got=trig%b %h ack%b err%b exp=trig1 123456 ack1 err0",
                trig_a, {hh_a, mm_a, ss_a}, ack_a, err_a);
        end
        tick();
        total++;
        if (trig_a !== 1'b0 || ack_a !== 1'b1) begin
            bad++; $display("FAIL set_hold got=trig%b ack%b exp=trig0 ack1", trig_a, ack_a);
        end
        set_req = 1'b0;
        tick();
        total++;
        if (ack_a !== 1'b0 || busy_a !== 1'b0 || {hh_a, mm_a, ss_a} !== 24'h123456) begin
            bad++; $display("FAIL set_release got=ack%b busy%b %h exp=ack0 busy0 123456", ack_a, busy_a, {hh_a, mm_a, ss_a});
        end
    endtask

    task automatic test_wrap();
        do_set(8'h23, 8'h59, 8'h58);
        one_hz = 1'b1; tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h235959 || sec_a !== 1'b1 || day_a !== 1'b0) begin
            bad++; $display("FAIL wrap_pre got=%h sec%b day%b exp=235959 sec1 day0", {hh_a, mm_a, ss_a}, sec_a, day_a);
        end
        one_hz = 1'b0; tick();
        one_hz = 1'b1; tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h000000 || sec_a !== 1'b1 || day_a !== 1'b1) begin
            bad++; $display("FAIL wrap_day got=%h sec%b day%b exp=000000 sec1 day1", {hh_a, mm_a, ss_a}, sec_a, day_a);
        end
        one_hz = 1'b0; tick();
        total++;
        if (day_a !== 1'b0 || sec_a !== 1'b0) begin
            bad++; $display("FAIL wrap_clear got=sec%b day%b exp=sec0 day0", sec_a, day_a);
        end
        do_set(8'h09, 8'h59, 8'h59);
        one_hz = 1'b1; tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h100000 || day_a !== 1'b0) begin
            bad++; $display("FAIL hour_carry got=%h day%b exp=100000 day0", {hh_a, mm_a, ss_a}, day_a);
        end
        one_hz = 1'b0; tick();
    endtask

    task automatic test_reject();
        do_set(8'h01, 8'h02, 8'h03);
        set_hh = 8'h24; set_mm = 8'h00; set_ss = 8'h00; set_req = 1'b1;
        tick(); tick();
        total++;
        if (ack_a !== 1'b1 || err_a !== 1'b1 || trig_a !== 1'b0) begin
            bad++; $display("FAIL rej_hh_ack got=ack%b err%b trig%b exp=ack1 err1 trig0", ack_a, err_a, trig_a);
        end
        tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h010203 || trig_a !== 1'b0 || ack_a !== 1'b1 || err_a !== 1'b1) begin
            bad++; $display("FAIL rej_hh_hold got=%h trig%b ack%b err%b exp=010203 trig0 ack1 err1",
                {hh_a, mm_a, ss_a}, trig_a, ack_a, err_a);
        end
        set_req = 1'b0; tick();
        total++;
        if (ack_a !== 1'b0 || err_a !== 1'b0) begin
            bad++; $display("FAIL rej_release got=ack%b err%b exp=ack0 err0", ack_a, err_a);
        end
        set_hh = 8'h00; set_mm = 8'h5A; set_ss = 8'h00; set_req = 1'b1;
        tick(); tick();
        total++;
        if (ack_a !== 1'b1 || err_a !== 1'b1) begin
            bad++; $display("FAIL rej_mm_ack got=ack%b err%b exp=ack1 err1", ack_a, err_a);
        end
        tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h010203 || trig_a !== 1'b0) begin
            bad++; $display("FAIL rej_mm_time got=%h trig%b exp=010203 trig0", {hh_a, mm_a, ss_a}, trig_a);
        end
        set_req = 1'b0; tick();
    endtask

    task automatic test_commit_collision();
        set_hh = 8'h05; set_mm = 8'h06; set_ss = 8'h07; set_req = 1'b1;
        tick(); tick();
        one_hz = 1'b1;
        tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h050607 || sec_a !== 1'b0 || trig_a !== 1'b1) begin
            bad++; $display("FAIL collide_commit got=%h sec%b trig%b exp=050607 sec0 trig1",
                {hh_a, mm_a, ss_a}, sec_a, trig_a);
        end
        one_hz = 1'b0; set_req = 1'b0;
        tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h050607 || sec_a !== 1'b0) begin
            bad++; $display("FAIL collide_after got=%h sec%b exp=050607 sec0", {hh_a, mm_a, ss_a}, sec_a);
        end
        one_hz = 1'b1; tick();
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h050608 || sec_a !== 1'b1) begin
            bad++; $display("FAIL collide_next got=%h sec%b exp=050608 sec1", {hh_a, mm_a, ss_a}, sec_a);
        end
        one_hz = 1'b0; tick();
    endtask

    task automatic test_12h();
        do_set(8'h11, 8'h59, 8'h59);
        one_hz = 1'b1; tick();
        total++;
        if ({hh_b, mm_b, ss_b} !== 24'h000000 || sec_b !== 1'b1 || day_b !== 1'b1) begin
            bad++; $display("FAIL h12_wrap got=%h sec%b day%b exp=000000 sec1 day1", {hh_b, mm_b, ss_b}, sec_b, day_b);
        end
        total++;
        if ({hh_a, mm_a, ss_a} !== 24'h120000 || day_a !== 1'b0) begin
            bad++; $display("FAIL h24_noon got=%h day%b exp=120000 day0", {hh_a, mm_a, ss_a}, day_a);
        end
        one_hz = 1'b0; tick();
        set_hh = 8'h12; set_mm = 8'h00; set_ss = 8'h00; set_req = 1'b1;
        tick(); tick();
        total++;
        if (ack_b !== 1'b1 || err_b !== 1'b1 || ack_a !== 1'b0) begin
            bad++; $display("FAIL h12_reject got=ackb%b errb%b acka%b exp=ackb1 errb1 acka0", ack_b, err_b, ack_a);
        end
        tick();
        total++;
        if (trig_b !== 1'b0 || {hh_b, mm_b, ss_b} !== 24'h000000 || trig_a !== 1'b1 || hh_a !== 8'h12 || err_a !== 1'b0) begin
            bad++; $display("FAIL h12_vs_h24 got=trigb%b b%h triga%b hha%h erra%b exp=trigb0 b000000 triga1 hha12 erra0",
                trig_b, {hh_b, mm_b, ss_b}, trig_a, hh_a, err_a);
        end
        set_req = 1'b0; tick();
    endtask

    task automatic test_reset_mid_handshake();
        set_hh = 8'h08; set_mm = 8'h00; set_ss = 8'h00; set_req = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        total++;
        if (ack_a !== 1'b0 || busy_a !== 1'b0 || {hh_a, mm_a, ss_a} !== 24'h000000) begin
            bad++; $display("FAIL mid_reset got=ack%b busy%b %h exp=ack0 busy0 000000", ack_a, busy_a, {hh_a, mm_a, ss_a});
        end
        set_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (ack_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL mid_reset_idle got=ack%b busy%b exp=ack0 busy0", ack_a, busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_wrap();
        test_reject();
        test_commit_collision();
        test_12h();
        test_reset_mid_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Time-of-day keeper that consumes the divider's one_hz output and drives the divider's trig input. It counts seconds, minutes and hours in packed BCD. It accepts a software time-set over a four-phase req/ack handshake. On every accepted set it issues a single-cycle trig pulse, so the divider re-phases and the first post-set second lasts a full period.

Parameters:
HOURS_PER_DAY, 24, hour modulus (12 or 24); the hour count runs 0..HOURS_PER_DAY-1.
PULSE_IN_SET, 1, 1 = trig pulses on every successful set; 0 = trig held at 0.

Ports:
clk  input  1  system clock, same domain as the divider.
rst  input  1  active-low asynchronous reset.
one_hz  input  1  divider output (level); each rising edge is one second.
set_req  input  1  time-set request (four-phase level).
set_hh  input  8  BCD hours to load.
set_mm  input  8  BCD minutes to load.
set_ss  input  8  BCD seconds to load.
set_ack  output  1  handshake acknowledge.
set_err  output  1  valid while set_ack=1; 1 = request rejected.
trig  output  1  single-cycle divider re-phase pulse.
hh  output  8  BCD hours.
mm  output  8  BCD minutes.
ss  output  8  BCD seconds.
sec_pulse  output  1  single-cycle pulse on each time advance.
day_pulse  output  1  single-cycle pulse when the time wraps to 00:00:00.
busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): hh/mm/ss=00, all pulses and set_ack/set_err/busy=0, FSM=IDLE, edge register one_hz_q=1. Presetting one_hz_q to 1 means a one_hz already high at reset release is not counted.
- Edge detect: adv = one_hz & ~one_hz_q; one_hz_q <= one_hz every cycle.
  - There is no synchroniser; one_hz is in the clk domain.
- Advance: on a clk edge where adv=1, time updates on that same edge, and sec_pulse=1 for exactly the following cycle. Latency from one_hz sampled high to new time visible: 1 cycle.
- Digit rules:
  - ss units 9->0 carries to ss tens; ss 59->00 carries to mm.
  - mm 59->00 carries to hh.
  - hh wraps to 00 at HOURS_PER_DAY; BCD tens/units handled, e.g. 09->10 and 23->00.
  - A full wrap 23:59:59->00:00:00 also pulses day_pulse with sec_pulse.
- FSM states: IDLE, CHECK, COMMIT, HOLD.
  - IDLE: set_req=1 -> capture set_* into shadow registers -> CHECK.
  - CHECK (1 cycle): shadow is valid if every nibble is <=9, ss<0x60, mm<0x60 and hh<HOURS_PER_DAY. Valid -> COMMIT; invalid -> HOLD with set_err=1, set_ack=1.
  - COMMIT (1 cycle): load shadow into hh/mm/ss and pulse trig (if PULSE_IN_SET). Next state HOLD with set_ack=1, set_err=0.
  - HOLD: keep set_ack and set_err until set_req=0, then clear both -> IDLE. set_ack falls on the cycle after set_req is sampled low.
- Simultaneous events:
  - adv during CHECK advances the live time normally.
  - adv in the COMMIT cycle is discarded: the load wins and there is no sec_pulse.
  - adv in HOLD/IDLE counts normally.
- set_* may change after capture; only the values present in the IDLE->CHECK cycle matter.
- A reset mid-handshake returns to IDLE with ack=0. The requester must drop and re-raise set_req.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release with one_hz=1 held -> no advance; time stays 00:00:00 until one_hz falls and rises again, then ss=01 and sec_pulse high for 1 cycle.
- Set 12:34:56 via handshake -> trig pulse 2 cycles after the set_req sample; hh/mm/ss=12/34/56 on that cycle; set_ack=1, set_err=0; ack clears 1 cycle after set_req drops.
- Set 23:59:58, then 2 one_hz edges -> 23:59:59, then 00:00:00 with day_pulse=1 coincident with sec_pulse.
- Set hh=0x24 (or mm=0x5A) -> set_ack=1, set_err=1, time and trig unchanged.
- Raise one_hz on the same cycle as COMMIT -> loaded value is shown, no sec_pulse; the next edge advances by exactly 1.
- HOURS_PER_DAY=12: from 11:59:59, one edge -> 00:00:00 with day_pulse; a set with hh=0x12 is rejected.
